instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
- Fetch/decode front end that drives the register-file command interface: the opcode, data and enable inputs of the REG stage.
- Reads 8-bit instruction bytes from a synchronous ROM and decodes single-byte and two-byte (immediate) instructions.
- Issues exactly one single-cycle enable pulse per register command. Handles JMP and HALT locally.
- Sits between PC/ROM and REG in the PC + ROM > Decoder > REG > ALU > FSM + UART chain.

Parameters:
- PC_WIDTH, 5, program counter and ROM address width; legal range 5..8.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ena  input  1  global enable; low freezes the sequencer.
- rom_addr  output  PC_WIDTH  ROM address; combinational copy of the pc register.
- rom_data  input  8  ROM read data; valid one cycle after rom_addr changes (synchronous ROM).
- reg_ena  output  1  one-cycle command strobe to REG.
- reg_opcode  output  3  command opcode to REG.
- reg_data  output  8  immediate data to REG; 0 for non-LOAD commands.
- pc  output  PC_WIDTH  current program counter (debug).
- halt  output  1  high once HALT has been decoded.

Behaviour:
- Reset (async, active-high): pc=0, state=FETCH, reg_ena=0, reg_opcode=3'b000, reg_data=8'h00, halt=0. Reset mid-instruction abandons it; no partial pulse is emitted.
- Instruction byte encoding: [7:5]=op, [4:0]=operand.
  - op 000: LOAD R0. Two bytes; byte 2 is the immediate.
  - op 001: LOAD R1. Two bytes; byte 2 is the immediate.
  - op 010–101: MOV R1←R0, MOV R0←R1, OUT R0, OUT R1. Single byte.
  - op 110: JMP to zero-extended [4:0].
  - op 111: HALT.
- All outputs except rom_addr are registered.
- FETCH: rom_addr=pc; go to DECODE; pc unchanged.
- DECODE (rom_data = instruction byte):
  - op 010–101: reg_ena<=1, reg_opcode<=op, reg_data<=0, pc<=pc+1, go to FETCH.
  - op 000/001: save op, pc<=pc+1, go to IMM_ADDR. No pulse yet.
  - op 110: pc<=operand, go to FETCH. No pulse.
  - op 111: halt<=1, go to HALTED. pc stays at the HALT address.
- IMM_ADDR: rom_addr=pc (immediate byte address); go to IMM.
- IMM: reg_ena<=1, reg_opcode<=saved op, reg_data<=rom_data, pc<=pc+1, go to FETCH.
- HALTED: terminal. Only reset exits. reg_ena stays 0.
- reg_ena is high for exactly one cycle per command. In every state other than the issuing transition it is cleared to 0. reg_opcode and reg_data hold their last value between pulses.
- Timing:
  - Single-byte register command: 2 cycles, pulse on the edge leaving DECODE.
  - LOAD: 4 cycles.
  - JMP: 2 cycles.
- pc arithmetic: modulo 2^PC_WIDTH. pc+1 at max address wraps to 0. An immediate byte located at address 0 after wrap is legal.
- JMP target is [4:0] zero-extended to PC_WIDTH.
- ena=0:
  - state, pc, halt and the saved op hold.
  - reg_ena clears to 0 at the next edge.
  - The ROM read in flight is re-presented: rom_addr is unchanged and the sequencer re-samples rom_data when ena returns.
- ena toggling never duplicates or drops a command.
- Reset has priority over ena.

Test Plan:
- ROM {0x02:0x40? n/a} program [0x00,0xA5,0x40,0x80,0xE0] from reset → reg_ena pulses at cycle 4 (op 000, data 0xA5), cycle 6 (op 010, data 0), cycle 8 (op 100, data 0). halt=1 after cycle 10 with pc=4. Exactly 3 pulses total.
- JMP loop [0x80,0xC0] → OUT R0 pulse every 4 cycles. pc alternates 0,1,0. No pulse for the JMP.
- PC_WIDTH=5, ROM[31]=0x20 (LOAD R1), ROM[0]=0x3C → pc wraps; pulse with op 001, data 0x3C; pc=1 afterwards.
- Deassert ena for 3 cycles during IMM_ADDR of LOAD 0x5A → single pulse with data 0x5A after re-enable. reg_ena=0 during the stall. pc frozen.
- Assert reset during IMM state → no pulse; all outputs at reset values within the same cycle. Fetch restarts at pc=0.
- After HALT, hold ena=1 for 20 cycles → reg_ena stays 0, halt=1, pc constant.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/decode front end: reads instruction bytes from a synchronous ROM and
// issues one-cycle register commands to the REG stage; JMP and HALT are handled locally.
module instr_sequencer #(
  parameter int unsigned PC_WIDTH = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ena,
  output logic [PC_WIDTH-1:0] rom_addr,
  input  logic [7:0]          rom_data,
  output logic                reg_ena,
  output logic [2:0]          reg_opcode,
  output logic [7:0]          reg_data,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halt
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StImmAddr,
    StImm,
    StHalted
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                halt_q, halt_d;
  logic                load_r1_q, load_r1_d;
  logic                reg_ena_q, reg_ena_d;
  logic [2:0]          reg_opcode_q, reg_opcode_d;
  logic [7:0]          reg_data_q, reg_data_d;
  logic [2:0]          op;

  assign op = rom_data[7:5];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    halt_d       = halt_q;
    load_r1_d    = load_r1_q;
    reg_ena_d    = 1'b0;
    reg_opcode_d = reg_opcode_q;
    reg_data_d   = reg_data_q;
    // With ena low everything holds; the ROM keeps re-reading the same address.
    if (ena) begin
      unique case (state_q)
        StFetch: state_d = StDecode;
        StDecode: begin
          unique case (op)
            3'b000, 3'b001: begin
              load_r1_d = op[0];
              pc_d      = pc_q + PC_WIDTH'(1);
              state_d   = StImmAddr;
            end
            3'b110: begin
              pc_d    = PC_WIDTH'(rom_data[4:0]);
              state_d = StFetch;
            end
            3'b111: begin
              halt_d  = 1'b1;
              state_d = StHalted;
            end
            default: begin
              reg_ena_d    = 1'b1;
              reg_opcode_d = op;
              reg_data_d   = 8'h00;
              pc_d         = pc_q + PC_WIDTH'(1);
              state_d      = StFetch;
            end
          endcase
        end
        StImmAddr: state_d = StImm;
        StImm: begin
          reg_ena_d    = 1'b1;
          reg_opcode_d = {2'b00, load_r1_q};
          reg_data_d   = rom_data;
          pc_d         = pc_q + PC_WIDTH'(1);
          state_d      = StFetch;
        end
        StHalted: state_d = StHalted;
        default:  state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StFetch;
      pc_q         <= '0;
      halt_q       <= 1'b0;
      load_r1_q    <= 1'b0;
      reg_ena_q    <= 1'b0;
      reg_opcode_q <= 3'b000;
      reg_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      halt_q       <= halt_d;
      load_r1_q    <= load_r1_d;
      reg_ena_q    <= reg_ena_d;
      reg_opcode_q <= reg_opcode_d;
      reg_data_q   <= reg_data_d;
    end
  end

  assign rom_addr   = pc_q;
  assign pc         = pc_q;
  assign halt       = halt_q;
  assign reg_ena    = reg_ena_q;
  assign reg_opcode = reg_opcode_q;
  assign reg_data   = reg_data_q;

endmodule
